queue_ctrl: RTL and testbench
=============================

QUEUE_CTRL -- requirements
Module: queue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, entry width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, RAM address width; depth = 2**ADDR_W entries (256).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push  input  1  enqueue request, one-cycle pulse from the single pulser.
REQ-006 SHALL have port pop  input  1  dequeue request, one-cycle pulse.
REQ-007 SHALL have port clear  input  1  empty the queue.
REQ-008 SHALL have port data_in  input  DATA_W  value to enqueue, sampled with push.
REQ-009 SHALL have port data_out  output  DATA_W  last dequeued value, held until the next dequeue.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse when data_out updates.
REQ-011 SHALL have port count  output  ADDR_W+1  number of stored entries, 0..256.
REQ-012 SHALL have ports empty, full, busy  output  1 each: count==0, count==2**ADDR_W, and state!=IDLE.
REQ-013 SHALL have port err  output  1  sticky misuse flag (see Configuration).

Function
REQ-014 SHALL implement FIFO order: head pointer reads, tail pointer writes, both ADDR_W bits wrapping 255->0.
REQ-015 SHALL use FSM states IDLE, WRITE, READ; WRITE and READ last exactly one cycle and return to IDLE.
REQ-016 In IDLE SHALL prioritise clear > pop > push when requests coincide; the losing request is dropped, not queued.
REQ-017 In IDLE, push with !full SHALL latch data_in and go to WRITE; in WRITE: mem[tail]<=latched data, tail+1, count+1.
REQ-018 In IDLE, pop with !empty SHALL go to READ; RAM read is synchronous and addressed by head during the IDLE cycle.
REQ-019 At the edge ending READ: data_out<=mem[head], head+1, count-1, out_valid=1 for the following cycle; pop-to-data latency = 2 clocks.
REQ-020 push while full and pop while empty SHALL be ignored with no pointer, count or RAM change.
REQ-021 push/pop arriving while busy SHALL be ignored.
REQ-022 clear in any state SHALL zero head, tail and count and force IDLE next cycle; a WRITE in progress SHALL be suppressed (no RAM write); data_out keeps its value.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, head=tail=0, count=0, data_out=0, out_valid=0, err=0, so empty=1, full=0, busy=0.
REQ-024 Reset asserted mid-WRITE or mid-READ SHALL abort the operation; RAM contents are not reset and are not required to be preserved.

Configuration
REQ-025 With macro QUEUE_ERR_EN defined, err SHALL set on any push-while-full or pop-while-empty in IDLE and clear only on clear or reset.
REQ-026 Without QUEUE_ERR_EN, err SHALL be tied to 0 and no error logic is synthesised.

Structure
REQ-027 Package queue_pkg SHALL hold the FSM state type (IDLE/WRITE/READ, 2-bit) and the default DATA_W/ADDR_W constants.
REQ-028 Storage SHALL be a separate sub-module queue_ram: single-port, synchronous write and registered read, DATA_W x 2**ADDR_W, inferring block RAM.

Verification
REQ-029 Reset, push 0x11, 0x22, 0x33, then 3 pops -> data_out 0x11, 0x22, 0x33, each with out_valid 2 clocks after its pop; count 3->0; empty=1.
REQ-030 256 pushes -> full=1, count=256; 257th push ignored; 256 pops return the pushed values in order, crossing the head/tail wrap 255->0.
REQ-031 Pop on empty queue -> no out_valid, count stays 0; with QUEUE_ERR_EN err=1 until clear, without it err=0.
REQ-032 push, pop and clear asserted in the same IDLE cycle with count=5 -> count=0, no RAM write, no out_valid.
REQ-033 Push accepted, then clear in the WRITE cycle -> count=0, tail=0; a subsequent push then pop returns the new value, not the aborted one.
REQ-034 rst_n pulsed low mid-READ -> outputs at reset values within the same cycle, no out_valid after release.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types and default sizes for the queue controller.
// The optional sticky error flag is enabled with the QUEUE_ERR_EN macro.
package queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/queue_ram.sv
// Single-port storage for the queue: synchronous write, registered read-first port.
module queue_ram
  import queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] rdata_r;

  // Block RAM port: no reset so the array maps onto dedicated memory
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/queue_ctrl.sv
// FIFO queue controller: IDLE/WRITE/READ sequencer around a single-port RAM.
// Define QUEUE_ERR_EN to build the sticky push-while-full / pop-while-empty flag.
module queue_ctrl
  import queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] head_r, tail_r;
  logic [ADDR_W:0]   count_r;
  logic [DATA_W-1:0] wdata_r, data_out_r, ram_rdata_s;
  logic              out_valid_r;
  logic              empty_s, full_s;
  logic              start_write_s, do_write_s, do_read_s;
  logic [ADDR_W-1:0] ram_addr_s;

  assign empty_s = (count_r == CNT_ZERO);
  assign full_s  = (count_r == CNT_FULL);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and datapath strobes; clear beats pop beats push in IDLE
  always_comb begin
    state_nxt_s   = IDLE;
    start_write_s = 1'b0;
    do_write_s    = 1'b0;
    do_read_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear) begin
          state_nxt_s = IDLE;
        end else if (pop) begin
          if (!empty_s) begin
            state_nxt_s = READ;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (push) begin
          if (!full_s) begin
            state_nxt_s   = WRITE;
            start_write_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (clear) begin
          do_write_s = 1'b0;
        end else begin
          do_write_s = 1'b1;
        end
      end
      READ: begin
        if (clear) begin
          do_read_s = 1'b0;
        end else begin
          do_read_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Head is presented during IDLE so the registered read is ready by the end of READ
  assign ram_addr_s = (state_r == WRITE) ? tail_r : head_r;

  queue_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (do_write_s),
    .addr (ram_addr_s),
    .wdata(wdata_r),
    .rdata(ram_rdata_s)
  );

  // Pointers, occupancy and output data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= PTR_ZERO;
      tail_r      <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      wdata_r     <= DATA_ZERO;
      data_out_r  <= DATA_ZERO;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (clear) begin
        head_r  <= PTR_ZERO;
        tail_r  <= PTR_ZERO;
        count_r <= CNT_ZERO;
      end else begin
        if (start_write_s) begin
          wdata_r <= data_in;
        end
        if (do_write_s) begin
          tail_r  <= tail_r + PTR_ONE;
          count_r <= count_r + CNT_ONE;
        end
        if (do_read_s) begin
          head_r      <= head_r + PTR_ONE;
          count_r     <= count_r - CNT_ONE;
          data_out_r  <= ram_rdata_s;
          out_valid_r <= 1'b1;
        end
      end
    end
  end

`ifdef QUEUE_ERR_EN
  logic err_r;
  logic err_set_s;

  // Only the request that wins arbitration in IDLE can flag misuse
  assign err_set_s = (state_r == IDLE) && !clear &&
                     ((pop && empty_s) || (!pop && push && full_s));

  // Sticky misuse flag, cleared by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (clear) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign data_out  = data_out_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_queue_ctrl.sv
// Randomised and directed bench for queue_ctrl against a queue-based reference model.
module tb_queue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       push, pop, clear;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       out_valid;
  logic [8:0] count;
  logic       empty, full, busy, err;

`ifdef QUEUE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents as a queue, plus at most one operation in flight
  logic [7:0] mq[$];
  int         m_pend;      // 0 none, 1 enqueue in flight, 2 dequeue in flight
  logic [7:0] m_pend_data;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_err;

  queue_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .data_in  (data_in),
    .data_out (data_out),
    .out_valid(out_valid),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend  = 0;
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic p, input logic po, input logic c, input logic [7:0] d);
    m_valid = 1'b0;
    if (c) begin
      mq.delete();
      m_pend = 0;
      m_err  = 1'b0;
    end else if (m_pend == 1) begin
      mq.push_back(m_pend_data);
      m_pend = 0;
    end else if (m_pend == 2) begin
      m_dout  = mq.pop_front();
      m_valid = 1'b1;
      m_pend  = 0;
    end else if (po) begin
      if (mq.size() > 0) m_pend = 2;
      else m_err = 1'b1;
    end else if (p) begin
      if (mq.size() < 256) begin
        m_pend      = 1;
        m_pend_data = d;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == 256));
    check("busy", 32'(busy), 32'(m_pend != 0));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("data_out", 32'(data_out), 32'(m_dout));
    check("err", 32'(err), 32'(ERR_EN ? m_err : 1'b0));
  endtask

  task automatic cyc(input logic p, input logic po, input logic c, input logic [7:0] d);
    push = p; pop = po; clear = c; data_in = d;
    @(posedge clk);
    model_edge(p, po, c, d);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_push(input logic [7:0] d);
    cyc(1'b1, 1'b0, 1'b0, d);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_pop();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; data_in = 8'h00;
    model_reset();
    #1;
    compare_all();
    #22;
    rst_n = 1'b1;
    idle(2);

    // Three pushes, three pops, with explicit two-clock latency checks
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    check("cnt3", 32'(count), 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("lat1_not_yet", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check("lat2_valid", 32'(out_valid), 32'd1);
    check("lat2_data", 32'(data_out), 32'h11);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check("valid_pulse", 32'(out_valid), 32'd0);
    check("data_hold", 32'(data_out), 32'h11);
    do_pop(); check("pop2_data", 32'(data_out), 32'h22);
    do_pop(); check("pop3_data", 32'(data_out), 32'h33);
    check("cnt0", 32'(count), 32'd0);
    check("empty_end", 32'(empty), 32'd1);

    // Pop on empty: ignored, err sticky when enabled
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);
    check("empty_pop_cnt", 32'(count), 32'd0);
    check("empty_pop_err", 32'(err), 32'(ERR_EN));
    do_push(8'h5A); do_pop();
    check("err_sticky", 32'(err), 32'(ERR_EN));
    do_clear();
    check("err_cleared", 32'(err), 32'd0);

    // Offset pointers, then fill to 256, over-push, and drain across the wrap
    for (int i = 0; i < 10; i++) begin do_push(8'(i)); do_pop(); end
    for (int i = 0; i < 256; i++) do_push(8'($urandom));
    check("full_flag", 32'(full), 32'd1);
    check("full_cnt", 32'(count), 32'd256);
    do_push(8'hEE);
    check("over_push_cnt", 32'(count), 32'd256);
    check("over_push_err", 32'(err), 32'(ERR_EN));
    for (int i = 0; i < 256; i++) do_pop();
    check("drained", 32'(empty), 32'd1);
    do_clear();

    // Coincident push/pop/clear with five entries
    for (int i = 0; i < 5; i++) do_push(8'(8'hA0 + i));
    cyc(1'b1, 1'b1, 1'b1, 8'hCC);
    check("coinc_cnt", 32'(count), 32'd0);
    check("coinc_busy", 32'(busy), 32'd0);
    idle(3);

    // Clear during WRITE aborts the write
    cyc(1'b1, 1'b0, 1'b0, 8'hDE);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    check("abort_cnt", 32'(count), 32'd0);
    do_push(8'h77); do_pop();
    check("abort_newval", 32'(data_out), 32'h77);

    // Asynchronous reset in the middle of READ
    do_push(8'h99); do_push(8'h98);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    compare_all();
    rst_n = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) < 50), ($urandom_range(99) < 40),
          ($urandom_range(199) < 3), 8'($urandom));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
